// File: rtl/aq_reduce_axis_out_pkg.sv
// Shared definitions for the reducer AXI4-Stream output stage: FIFO word layout and ARGB packing.
package aq_reduce_axis_out_pkg;

   localparam int unsigned ARGB_W    = 32;
   localparam int unsigned TLAST_BIT = 32;
   localparam int unsigned TUSER_BIT = 33;
   localparam int unsigned FIFO_DW   = 34;

   function automatic logic [ARGB_W-1:0] pack_argb(input logic [7:0] a, input logic [7:0] r,
                                                   input logic [7:0] g, input logic [7:0] b);
      return {a, r, g, b};
   endfunction

endpackage

// File: rtl/aq_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; writes when full and reads
// when empty are ignored.
module aq_sync_fifo #(
   parameter int unsigned DW = 34,
   parameter int unsigned AW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WR_EN,
   input  logic [DW-1:0] WR_DATA,
   input  logic          RD_EN,
   output logic [DW-1:0] RD_DATA,
   output logic          FULL,
   output logic          EMPTY,
   output logic [AW:0]   LEVEL
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic          do_wr, do_rd;

   always_comb begin
      FULL    = (level_q == (AW+1)'(DEPTH));
      EMPTY   = (level_q == '0);
      do_wr   = WR_EN & ~FULL;
      do_rd   = RD_EN & ~EMPTY;
      level_d = level_q;
      unique case ({do_wr, do_rd})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

   // Storage needs no reset; EMPTY gates everything read from it.
   always_ff @(posedge CLK) begin
      if (do_wr) mem_q[wr_ptr_q] <= WR_DATA;
   end

   assign RD_DATA = mem_q[rd_ptr_q];
   assign LEVEL   = level_q;

endmodule

// File: rtl/aq_reduce_axis_out.sv
// Converts the reducer's strobed ARGB stream into an AXI4-Stream video master, buffering beats
// in a FIFO and flagging overflow and line-length errors.
module aq_reduce_axis_out
   import aq_reduce_axis_out_pkg::*;
#(
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned XW      = 11
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [XW-1:0]    CNV_X,
   input  logic             DIN_OE,
   input  logic             DIN_START_X,
   input  logic             DIN_START_Y,
   input  logic [7:0]       DIN_A,
   input  logic [7:0]       DIN_R,
   input  logic [7:0]       DIN_G,
   input  logic [7:0]       DIN_B,
   output logic [31:0]      M_AXIS_TDATA,
   output logic             M_AXIS_TVALID,
   input  logic             M_AXIS_TREADY,
   output logic             M_AXIS_TUSER,
   output logic             M_AXIS_TLAST,
   input  logic             CLEAR,
   output logic             OVERFLOW,
   output logic             LINE_ERR,
   output logic [FIFO_AW:0] LEVEL
);

   logic [XW-1:0]      x_cnt_q, x_cnt_d, x_cur;
   logic               first_q, first_d;
   logic               overflow_q, overflow_d;
   logic               line_err_q, line_err_d;
   logic               tag_user, tag_last, line_bad;
   logic               push, pop, fifo_full, fifo_empty;
   logic [FIFO_DW-1:0] wr_word, rd_word;

   always_comb begin
      x_cur    = DIN_START_X ? '0 : x_cnt_q;
      tag_user = DIN_START_X & DIN_START_Y;
      tag_last = (CNV_X <= XW'(1)) || (x_cur == CNV_X - XW'(1));
      // The first pixel after reset has no preceding line to judge.
      line_bad = (DIN_START_X && !first_q && (x_cnt_q != CNV_X)) ||
                 ((CNV_X > XW'(1)) && (x_cur >= CNV_X));
      wr_word  = {tag_user, tag_last, pack_argb(DIN_A, DIN_R, DIN_G, DIN_B)};
      push     = DIN_OE & ~fifo_full;
      pop      = M_AXIS_TVALID & M_AXIS_TREADY;

      x_cnt_d    = x_cnt_q;
      first_d    = first_q;
      overflow_d = overflow_q;
      line_err_d = line_err_q;
      if (DIN_OE) begin
         // Counter advances even on a dropped pixel so later tags stay aligned.
         x_cnt_d = (&x_cur) ? x_cur : x_cur + 1'b1;
         first_d = 1'b0;
      end
      if (CLEAR) begin
         overflow_d = 1'b0;
         line_err_d = 1'b0;
      end
      if (DIN_OE && fifo_full) overflow_d = 1'b1;
      if (DIN_OE && line_bad)  line_err_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         x_cnt_q    <= '0;
         first_q    <= 1'b1;
         overflow_q <= 1'b0;
         line_err_q <= 1'b0;
      end else begin
         x_cnt_q    <= x_cnt_d;
         first_q    <= first_d;
         overflow_q <= overflow_d;
         line_err_q <= line_err_d;
      end
   end

   aq_sync_fifo #(
      .DW (FIFO_DW),
      .AW (FIFO_AW)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .WR_EN   (push),
      .WR_DATA (wr_word),
      .RD_EN   (pop),
      .RD_DATA (rd_word),
      .FULL    (fifo_full),
      .EMPTY   (fifo_empty),
      .LEVEL   (LEVEL)
   );

   always_comb begin
      M_AXIS_TVALID = ~fifo_empty;
      M_AXIS_TDATA  = fifo_empty ? '0 : rd_word[ARGB_W-1:0];
      M_AXIS_TUSER  = ~fifo_empty & rd_word[TUSER_BIT];
      M_AXIS_TLAST  = ~fifo_empty & rd_word[TLAST_BIT];
   end

   assign OVERFLOW = overflow_q;
   assign LINE_ERR = line_err_q;

endmodule
